fsm_run_generator: RTL and testbench

Serial run-pattern transmitter: the producer end of the single-bit run-detection link. It accepts run commands (bit value, run length) through a valid/ready handshake, buffers them in a small FIFO, and emits the runs one bit per clock on W/W_VALID. It also drives S_EXP, the registered expectation of the downstream run detector's output, so a bench or self-test can compare it against the detector directly.

---
 rtl/fsm_run_generator_pkg.sv | 18 +
 rtl/fsm_run_generator_if.sv | 15 +
 rtl/fsm_run_generator_fifo.sv | 61 ++++++
 rtl/fsm_run_generator.sv | 122 ++++++++++++
 tb/tb_fsm_run_generator.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_run_generator_pkg.sv
// Shared types and defaults for the run-pattern transmitter.
// Holds the engine state enum, the default widths and the command record.
package fsm_run_pkg;

    localparam int LEN_W_DEF     = 4;
    localparam int MATCH_LEN_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } engState_t;

    typedef struct packed {
        logic                 bitVal;
        logic [LEN_W_DEF-1:0] len;
    } runCmd_t;

endpackage

// File: rtl/fsm_run_generator_if.sv
// Command handshake into the run-pattern transmitter.
// The master offers {CMD_BIT, CMD_LEN}, and the slave answers with CMD_READY.
interface fsm_run_generator_if
    import fsm_run_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) ();
    logic             CMD_VALID;
    logic             CMD_READY;
    logic             CMD_BIT;
    logic [LEN_W-1:0] CMD_LEN;

    modport master (output CMD_VALID, output CMD_BIT, output CMD_LEN, input CMD_READY);
    modport slave  (input CMD_VALID, input CMD_BIT, input CMD_LEN, output CMD_READY);
endinterface

// File: rtl/fsm_run_generator_fifo.sv
// run_cmd_fifo: synchronous FIFO used to queue run commands.
// It has a combinational head read, and its count carries one extra bit so that full and empty can be told apart.
module run_cmd_fifo
    import fsm_run_pkg::*;
#(
    parameter int WIDTH = LEN_W_DEF + 1,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr];

    // The storage array carries no reset; only the pointers and the count define what it holds.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fsm_run_generator.sv
// fsm_run_generator: queues run commands and emits them on W/W_VALID one bit per clock.
// S_EXP predicts the output of the downstream run detector in the same register stage.
module fsm_run_generator
    import fsm_run_pkg::*;
#(
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int MATCH_LEN  = MATCH_LEN_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    fsm_run_generator_if.slave cmd,
    output logic               W,
    output logic               W_VALID,
    output logic               S_EXP,
    output logic               BUSY
);
    // state | meaning
    // IDLE  | no run in progress; pops the FIFO head when one is available
    // EMIT  | repeating the current bit until rem reaches zero
    localparam int CNT_W = $clog2(MATCH_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MATCH_LEN);

    engState_t        state;
    logic [LEN_W-1:0] rem;
    logic [CNT_W-1:0] runCnt;
    logic             lastBit;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [LEN_W:0]   pushData;
    logic [LEN_W:0]   headData;
    logic [LEN_W-1:0] headLen;
    logic             headBit;

    logic             issueRep;
    logic             issueFirst;
    logic             issue;
    logic             bitNext;
    logic [CNT_W-1:0] runNext;

    assign cmd.CMD_READY = !full && !RST;
    assign push          = cmd.CMD_VALID && cmd.CMD_READY;
    assign pushData      = {cmd.CMD_BIT, cmd.CMD_LEN};
    assign headLen       = headData[LEN_W-1:0];
    assign headBit       = headData[LEN_W];

    run_cmd_fifo #(
        .WIDTH(LEN_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push    (push),
        .pop     (pop),
        .pushData(pushData),
        .popData (headData),
        .full    (full),
        .empty   (empty)
    );

    // A pop happens whenever the engine is free to take a new command.
    // A popped zero-length command is consumed without issuing a bit.
    assign pop        = !RST && !empty && ((state == IDLE) || (rem == '0));
    assign issueRep   = (state == EMIT) && (rem != '0);
    assign issueFirst = pop && (headLen != '0);
    assign issue      = issueRep || issueFirst;
    assign bitNext    = issueFirst ? headBit : W;
    assign BUSY       = !empty || (state == EMIT);

    always_comb begin
        runNext = CNT_W'(1);
        if ((runCnt != '0) && (bitNext == lastBit)) begin
            runNext = (runCnt == CNT_MAX) ? CNT_MAX : runCnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            rem     <= '0;
            runCnt  <= '0;
            lastBit <= 1'b0;
            W       <= 1'b0;
            W_VALID <= 1'b0;
            S_EXP   <= 1'b0;
        end else begin
            if (issue) begin
                W       <= bitNext;
                W_VALID <= 1'b1;
                S_EXP   <= (runNext == CNT_MAX);
                runCnt  <= runNext;
                lastBit <= bitNext;
            end else begin
                W_VALID <= 1'b0;
                S_EXP   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (issueFirst) begin
                        rem   <= headLen - 1'b1;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (rem != '0) begin
                        rem <= rem - 1'b1;
                    end else if (issueFirst) begin
                        rem <= headLen - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_run_generator.sv
// Bench for fsm_run_generator: a per-cycle vector table, directed corner sequences and
// random traffic checked against a queue model of the expected bit stream.
module tb_fsm_run_generator;
    import fsm_run_pkg::*;

    localparam int LEN_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int MATCH_LEN  = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic W, W_VALID, S_EXP, BUSY;

    fsm_run_generator_if #(.LEN_W(LEN_W)) cmdIf ();

    fsm_run_generator #(
        .LEN_W     (LEN_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MATCH_LEN (MATCH_LEN)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .cmd    (cmdIf),
        .W      (W),
        .W_VALID(W_VALID),
        .S_EXP  (S_EXP),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Expected stream of valid bits: {W, S_EXP} per emitted bit, gaps ignored.
    logic [1:0] expQ[$];
    int         mCnt;
    logic       mLast;
    logic       modelOn;
    logic       lastPushed;

    typedef struct packed {
        logic       v;
        logic       b;
        logic [3:0] len;
        logic       expWv;
        logic       expW;
        logic       expS;
        logic       expBusy;
    } vec_t;

    vec_t vecs[21];

    function automatic vec_t mk(input logic v, input logic b, input logic [3:0] len,
                                input logic wv, input logic w, input logic s, input logic busy);
        vec_t r;
        r.v = v; r.b = b; r.len = len;
        r.expWv = wv; r.expW = w; r.expS = s; r.expBusy = busy;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic modelPush(input logic b, input logic [3:0] len);
        for (int i = 0; i < int'(len); i++) begin
            if (mCnt != 0 && b == mLast) mCnt = (mCnt + 1 > MATCH_LEN) ? MATCH_LEN : mCnt + 1;
            else mCnt = 1;
            mLast = b;
            expQ.push_back({b, logic'(mCnt == MATCH_LEN)});
        end
    endtask

    task automatic modelClear();
        expQ.delete();
        mCnt  = 0;
        mLast = 1'b0;
    endtask

    task automatic monitor();
        logic [1:0] e;
        if (expQ.size() == 0) begin
            check("stray_valid", int'(W_VALID), 0);
        end else if (W_VALID) begin
            e = expQ.pop_front();
            check("stream_w", int'(W), int'(e[1]));
            check("stream_sexp", int'(S_EXP), int'(e[0]));
        end
        if (!W_VALID) check("sexp_when_invalid", int'(S_EXP), 0);
    endtask

    // Drive one cycle from just after a falling edge, then land on the next falling edge.
    task automatic tick(input logic v, input logic b, input logic [3:0] len);
        cmdIf.CMD_VALID = v;
        cmdIf.CMD_BIT   = b;
        cmdIf.CMD_LEN   = len;
        #1;
        lastPushed = v && cmdIf.CMD_READY;
        if (lastPushed && modelOn) modelPush(b, len);
        @(posedge CLK);
        @(negedge CLK);
        if (modelOn) monitor();
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b0, 4'd0);
        RST = 1'b0;
        modelClear();
        tick(1'b0, 1'b0, 4'd0);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || BUSY) && n < budget) begin
            tick(1'b0, 1'b0, 4'd0);
            n++;
        end
        check({name, "_bits_left"}, expQ.size(), 0);
        check({name, "_busy_after"}, int'(BUSY), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, runLen;
        logic ended, bubble, rdyLow, rdyBack;

        cmdIf.CMD_VALID = 1'b0;
        cmdIf.CMD_BIT   = 1'b0;
        cmdIf.CMD_LEN   = '0;
        modelOn = 1'b0;
        modelClear();

        //                v     b     len    wv    w     s     busy
        vecs[0]  = mk(1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[2]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[5]  = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[7]  = mk(1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[8]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[12] = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[14] = mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[15] = mk(1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[16] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        vecs[17] = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[18] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[19] = mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        vecs[20] = mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset values while RST is still high
        @(negedge CLK);
        tick(1'b0, 1'b0, 4'd0);
        tick(1'b0, 1'b0, 4'd0);
        check("rst_w", int'(W), 0);
        check("rst_wvalid", int'(W_VALID), 0);
        check("rst_sexp", int'(S_EXP), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_ready_low", int'(cmdIf.CMD_READY), 0);
        RST = 1'b0;
        tick(1'b0, 1'b0, 4'd0);
        check("post_rst_ready", int'(cmdIf.CMD_READY), 1);
        check("post_rst_busy", int'(BUSY), 0);

        // Cycle-exact table: (1,4); (0,2)+(0,3) merge; (1,3),(0,0),(1,2) gap
        for (int i = 0; i < 21; i++) begin
            tick(vecs[i].v, vecs[i].b, vecs[i].len);
            check($sformatf("vec%0d_wvalid", i), int'(W_VALID), int'(vecs[i].expWv));
            if (vecs[i].expWv) check($sformatf("vec%0d_w", i), int'(W), int'(vecs[i].expW));
            check($sformatf("vec%0d_sexp", i), int'(S_EXP), int'(vecs[i].expS));
            check($sformatf("vec%0d_busy", i), int'(BUSY), int'(vecs[i].expBusy));
            check($sformatf("vec%0d_ready", i), int'(cmdIf.CMD_READY), 1);
        end

        // Six LEN=15 commands with CMD_VALID held: FIFO fills, stream stays continuous
        doReset();
        modelOn = 1'b1;
        sent = 0; runLen = 0;
        ended = 1'b0; bubble = 1'b0; rdyLow = 1'b0; rdyBack = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (sent == 6 && expQ.size() == 0 && !BUSY) break;
            tick(logic'(sent < 6), logic'(sent % 2), 4'd15);
            if (lastPushed) sent++;
            if (W_VALID) begin
                if (ended) bubble = 1'b1;
                runLen++;
            end else if (runLen > 0) begin
                ended = 1'b1;
            end
            if (!cmdIf.CMD_READY) rdyLow = 1'b1;
            else if (rdyLow) rdyBack = 1'b1;
        end
        check("full_sent", sent, 6);
        check("full_total_bits", runLen, 90);
        check("full_bubble", int'(bubble), 0);
        check("full_ready_dropped", int'(rdyLow), 1);
        check("full_ready_back", int'(rdyBack), 1);
        drain("full", 50);

        // Reset during the third bit of (1,8) with two commands queued
        doReset();
        modelOn = 1'b1;
        tick(1'b1, 1'b1, 4'd8);
        tick(1'b1, 1'b0, 4'd5);
        tick(1'b1, 1'b1, 4'd4);
        tick(1'b0, 1'b0, 4'd0);
        check("pre_rst_bit3_valid", int'(W_VALID), 1);
        RST = 1'b1;
        modelClear();
        tick(1'b0, 1'b0, 4'd0);
        check("midrst_wvalid", int'(W_VALID), 0);
        check("midrst_sexp", int'(S_EXP), 0);
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_ready", int'(cmdIf.CMD_READY), 0);
        RST = 1'b0;
        tick(1'b0, 1'b0, 4'd0);
        check("after_midrst_wvalid", int'(W_VALID), 0);
        check("after_midrst_busy", int'(BUSY), 0);
        tick(1'b1, 1'b1, 4'd1);
        tick(1'b0, 1'b0, 4'd0);
        check("single_bit_valid", int'(W_VALID), 1);
        check("single_bit_sexp", int'(S_EXP), 0);
        drain("midrst", 20);

        // Random traffic against the stream model
        doReset();
        modelOn = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
        end
        drain("random", 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
